dual_register: RTL and testbench



---
 rtl/dual_register_if.sv | 24 ++
 rtl/dual_register.sv | 27 ++
 tb/tb_dual_register.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dual_register_if.sv
// Signal bundle for the dual_register retiming stage: flag and word inputs with
// their registered copies.
interface dual_register_if #(
   parameter int DATA_W = 4
);
   logic              in1;
   logic [DATA_W-1:0] in2;
   logic              out1;
   logic [DATA_W-1:0] out2;

   modport master (
      output in1,
      output in2,
      input  out1,
      input  out2
   );

   modport slave (
      input  in1,
      input  in2,
      output out1,
      output out2
   );
endinterface

// File: rtl/dual_register.sv
// Single-stage retiming register: a 1-bit flag and a DATA_W-bit word are
// captured on every rising clock edge, and an asynchronous reset clears both.
module dual_register #(
   parameter int DATA_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   dual_register_if.slave  bus
);
   logic              flag_p0;
   logic [DATA_W-1:0] word_p0;

   // Stage 0: both banks clear asynchronously, because the outputs must be
   // zero for as long as rst is high, including between clock edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_p0 <= 1'b0;
         word_p0 <= '0;
      end else begin
         flag_p0 <= bus.in1;
         word_p0 <= bus.in2;
      end
   end

   assign bus.out1 = flag_p0;
   assign bus.out2 = word_p0;
endmodule

// File: tb/tb_dual_register.sv
// Self-checking bench for dual_register: directed reset/capture scenarios and
// randomized traffic compared each cycle against a capture-history model.
module tb_dual_register;
   localparam int DATA_W = 4;

   logic clk;
   logic rst;

   dual_register_if #(.DATA_W(DATA_W)) bus ();

   dual_register #(.DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state: every sample taken at an edge with rst low, plus a flag
   // that says whether a reset has occurred since the most recent capture.
   logic [DATA_W:0] hist[$];
   bit              cleared = 1'b1;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [DATA_W:0] model_out();
      if (cleared || hist.size() == 0) return '0;
      return hist[hist.size()-1];
   endfunction

   task automatic chk_model(input string nm);
      logic [DATA_W:0] e;
      e = model_out();
      chk({nm, "_out1"}, {7'd0, bus.out1}, {7'd0, e[DATA_W]});
      chk({nm, "_out2"}, {{(8-DATA_W){1'b0}}, bus.out2}, {{(8-DATA_W){1'b0}}, e[DATA_W-1:0]});
   endtask

   task automatic chk_lit(input string nm, input logic o1, input logic [DATA_W-1:0] o2);
      chk({nm, "_out1"}, {7'd0, bus.out1}, {7'd0, o1});
      chk({nm, "_out2"}, {{(8-DATA_W){1'b0}}, bus.out2}, {{(8-DATA_W){1'b0}}, o2});
   endtask

   initial begin
      rst     = 1'b1;
      bus.in1 = 1'b0;
      bus.in2 = '0;
      fork
         // Model update: a reset rise clears, a clean edge records the inputs.
         forever begin
            @(posedge clk or posedge rst);
            if (rst) cleared = 1'b1;
            else begin
               cleared = 1'b0;
               hist.push_back({bus.in1, bus.in2});
            end
         end
         // Per-cycle compare, away from the active edge.
         forever begin
            @(negedge clk);
            chk_model("cycle");
         end
         // Watchdog.
         begin
            #200000;
            errors++;
            $display("FAIL watchdog: stimulus did not complete, expected completion before %0t", $time);
         end
         // Stimulus.
         begin
            // Power-up under reset.
            repeat (3) begin
               @(negedge clk);
               chk_lit("powerup", 1'b0, 4'b0000);
            end
            // Release and capture.
            @(negedge clk);
            rst = 1'b0;
            chk_lit("release_idle", 1'b0, 4'b0000);
            @(negedge clk);
            bus.in1 = 1'b1;
            chk_lit("in1_pre_edge", 1'b0, 4'b0000);
            @(negedge clk);
            chk_lit("in1_captured", 1'b1, 4'b0000);
            bus.in2 = 4'b1010;
            @(negedge clk);
            chk_lit("in2_captured", 1'b1, 4'b1010);
            @(negedge clk);
            chk_lit("hold", 1'b1, 4'b1010);
            // Asynchronous reset mid-cycle.
            @(posedge clk);
            #2 rst = 1'b1;
            #1 chk_lit("async_rst", 1'b0, 4'b0000);
            // Inputs ignored during reset.
            @(negedge clk);
            bus.in1 = 1'b0;
            bus.in2 = 4'b0000;
            @(negedge clk);
            bus.in1 = 1'b1;
            bus.in2 = 4'b1111;
            @(negedge clk);
            chk_lit("rst_ignores_in", 1'b0, 4'b0000);
            // Re-release with inputs already applied.
            rst = 1'b0;
            #1 chk_lit("rerelease_wait", 1'b0, 4'b0000);
            @(posedge clk);
            #1 chk_lit("rerelease_cap", 1'b1, 4'b1111);
            // Input change 1 ns after an edge stays invisible until the next.
            @(posedge clk);
            #1 bus.in2 = 4'b0011;
            #1 chk_lit("edge_align_old", 1'b1, 4'b1111);
            @(posedge clk);
            #1 chk_lit("edge_align_new", 1'b1, 4'b0011);
            // Randomized traffic with occasional mid-cycle reset pulses.
            for (int i = 0; i < 400; i++) begin
               @(negedge clk);
               rst     = 1'b0;
               bus.in1 = 1'($urandom);
               bus.in2 = DATA_W'($urandom);
               if ($urandom_range(0, 19) == 0) begin
                  #($urandom_range(1, 3)) rst = 1'b1;
                  #1 chk_model("rand_async");
               end else if ($urandom_range(0, 9) == 0) begin
                  // Glitch between edges that must not reach the outputs.
                  bus.in2 = ~bus.in2;
                  #2 bus.in2 = ~bus.in2;
               end
            end
            @(negedge clk);
            rst = 1'b0;
            repeat (3) @(negedge clk);
         end
      join_any
      disable fork;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
